// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined datapath: opcodes, ALU ops,
// forwarding-select encoding and the in-flight destination history entry.
package cpu_pkg;

  localparam int REG_W = 5;

  typedef enum logic [5:0] {
    OP_NOP  = 6'd0,
    OP_ADD  = 6'd1,
    OP_SUB  = 6'd2,
    OP_AND  = 6'd3,
    OP_OR   = 6'd4,
    OP_ADDI = 6'd5,
    OP_LD   = 6'd6,
    OP_ST   = 6'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4
  } alu_op_e;

  localparam logic [1:0] FWD_BANK = 2'b00;
  localparam logic [1:0] FWD_EX   = 2'b01;
  localparam logic [1:0] FWD_DM   = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } hist_t;

endpackage

// File: rtl/fwd_compare.sv
// Matches one source register against the destination history and returns
// the forwarding select plus whether the distance-1 producer is a load.
module fwd_compare
  import cpu_pkg::*;
(
  input  hist_t [2:0]      hist,
  input  logic [REG_W-1:0] rs,
  output logic [1:0]       sel,
  output logic             load_hit
);

  logic [2:0] hit;
  logic       prod_load;

  // r0 is hardwired in the bank, so it never matches a producer
  always_comb begin
    hit = '0;
    for (int i = 0; i < 3; i++) begin
      hit[i] = hist[i].valid && (hist[i].rd != '0) && (hist[i].rd == rs);
    end
  end

  always_comb begin
    sel       = FWD_BANK;
    prod_load = 1'b0;
    if (hit[0]) begin
      sel       = FWD_EX;
      prod_load = hist[0].is_load;
    end else if (hit[1]) begin
      sel       = FWD_DM;
      prod_load = hist[1].is_load;
    end else if (hit[2]) begin
      sel       = FWD_WB;
      prod_load = hist[2].is_load;
    end
  end

  assign load_hit = (sel == FWD_EX) && prod_load;

endmodule

// File: rtl/instr_decode_fwd.sv
// Decode stage: holds one instruction, drives bank read addresses, resolves
// RAW hazards by forwarding and inserts a one-cycle bubble on load-use.
module instr_decode_fwd
  import cpu_pkg::*;
#(
  parameter  int NUM_REGS = 32,
  parameter  int DATA_W   = 16,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              flush,
  output logic [AW-1:0]     RA,
  output logic [AW-1:0]     RB,
  output logic [1:0]        mux_sel_A,
  output logic [1:0]        mux_sel_B,
  output logic [DATA_W-1:0] imm,
  output logic              imm_sel,
  output logic [2:0]        alu_op,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [AW-1:0]     RW_dm,
  output logic              stall
);

  function automatic logic signed [DATA_W-1:0] sext_imm(input logic signed [15:0] f);
    return DATA_W'(f);
  endfunction

  logic             dec_valid;
  logic [31:0]      dec_instr;
  logic [5:0]       opcode;
  logic [REG_W-1:0] rd, rs1, rs2;
  logic             is_r, is_addi, is_ld, is_st;
  alu_op_e          alu_d;
  logic             use_rs1, use_rs2, writes_rd, imm_sel_d;
  logic [1:0]       sel_a_raw, sel_b_raw;
  logic             ld_hit_a, ld_hit_b;
  logic             stall_d, issue;
  hist_t [2:0]      hist;
  hist_t            entry_d;

  logic                     vld_p1;
  logic [1:0]               sel_a_p1, sel_b_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic                     imm_sel_p1, mem_rd_p1, mem_wr_p1;
  alu_op_e                  alu_op_p1;

  assign opcode = dec_instr[31:26];
  assign rd     = dec_instr[25:21];
  assign rs1    = dec_instr[20:16];
  assign rs2    = dec_instr[15:11];

  always_comb begin
    is_r    = 1'b0;
    is_addi = 1'b0;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    alu_d   = ALU_NOP;
    case (opcode)
      OP_ADD:  begin is_r    = 1'b1; alu_d = ALU_ADD; end
      OP_SUB:  begin is_r    = 1'b1; alu_d = ALU_SUB; end
      OP_AND:  begin is_r    = 1'b1; alu_d = ALU_AND; end
      OP_OR:   begin is_r    = 1'b1; alu_d = ALU_OR;  end
      OP_ADDI: begin is_addi = 1'b1; alu_d = ALU_ADD; end
      OP_LD:   begin is_ld   = 1'b1; alu_d = ALU_ADD; end
      OP_ST:   begin is_st   = 1'b1; alu_d = ALU_ADD; end
      default: ;
    endcase
  end

  // ST computes its address from rs1+imm and carries rs2 as store data
  assign use_rs1   = is_r || is_addi || is_ld || is_st;
  assign use_rs2   = is_r || is_st;
  assign writes_rd = (is_r || is_addi || is_ld) && (rd != '0);
  assign imm_sel_d = is_addi || is_ld || is_st;

  fwd_compare u_fwd_a (
    .hist     (hist),
    .rs       (rs1),
    .sel      (sel_a_raw),
    .load_hit (ld_hit_a)
  );

  fwd_compare u_fwd_b (
    .hist     (hist),
    .rs       (rs2),
    .sel      (sel_b_raw),
    .load_hit (ld_hit_b)
  );

  assign stall_d = dec_valid && ((use_rs1 && ld_hit_a) || (use_rs2 && ld_hit_b));
  assign issue   = dec_valid && !stall_d && !flush;

  always_comb begin
    entry_d         = '0;
    entry_d.valid   = issue && writes_rd;
    entry_d.rd      = rd;
    entry_d.is_load = is_ld;
  end

  // Decode slot: flush empties it, stall holds it, otherwise take from fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid <= 1'b0;
    end else if (flush) begin
      dec_valid <= 1'b0;
    end else if (!stall_d) begin
      dec_valid <= instr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && !stall_d && instr_valid) begin
      dec_instr <= instr;
    end
  end

  // Decode -> EX boundary; the history shifts every cycle, bubbles included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      hist   <= {hist[1:0], entry_d};
      vld_p1 <= issue;
    end
  end

  always_ff @(posedge clk) begin
    sel_a_p1   <= use_rs1 ? sel_a_raw : FWD_BANK;
    sel_b_p1   <= use_rs2 ? sel_b_raw : FWD_BANK;
    imm_p1     <= sext_imm($signed(dec_instr[15:0]));
    imm_sel_p1 <= imm_sel_d;
    alu_op_p1  <= alu_d;
    mem_rd_p1  <= is_ld;
    mem_wr_p1  <= is_st;
  end

  assign mux_sel_A = vld_p1 ? sel_a_p1 : FWD_BANK;
  assign mux_sel_B = vld_p1 ? sel_b_p1 : FWD_BANK;
  assign imm       = vld_p1 ? imm_p1 : '0;
  assign imm_sel   = vld_p1 && imm_sel_p1;
  assign alu_op    = vld_p1 ? alu_op_p1 : ALU_NOP;
  assign mem_rd    = vld_p1 && mem_rd_p1;
  assign mem_wr    = vld_p1 && mem_wr_p1;

  assign RA          = dec_valid ? AW'(rs1) : '0;
  assign RB          = dec_valid ? AW'(rs2) : '0;
  assign RW_dm       = hist[1].valid ? AW'(hist[1].rd) : '0;
  assign stall       = stall_d;
  assign instr_ready = !stall_d;

endmodule

// File: tb/tb_instr_decode_fwd.sv
// Directed bench for instr_decode_fwd: forwarding distances, priority,
// load-use stall, flush during stall and asynchronous reset.
module tb_instr_decode_fwd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        flush = 1'b0;
  logic        instr_ready;
  logic [4:0]  RA, RB, RW_dm;
  logic [1:0]  mux_sel_A, mux_sel_B;
  logic [15:0] imm;
  logic        imm_sel, mem_rd, mem_wr, stall;
  logic [2:0]  alu_op;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_decode_fwd #(.NUM_REGS(32), .DATA_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .flush       (flush),
    .RA          (RA),
    .RB          (RB),
    .mux_sel_A   (mux_sel_A),
    .mux_sel_B   (mux_sel_B),
    .imm         (imm),
    .imm_sel     (imm_sel),
    .alu_op      (alu_op),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .RW_dm       (RW_dm),
    .stall       (stall)
  );

  function automatic logic [31:0] r_op(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'd0};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [15:0] im);
    return {op, rd, rs1, im};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] w);
    instr = w;
    instr_valid = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    #12;
    checks++; if ({mux_sel_A, mux_sel_B, imm, imm_sel, alu_op, mem_rd, mem_wr, RW_dm, stall, RA, RB, instr_ready} !== 43'd1) begin
      failures++; $display("FAIL reset_vals got=%h exp=%h", {mux_sel_A, mux_sel_B, imm, imm_sel, alu_op, mem_rd, mem_wr, RW_dm, stall, RA, RB, instr_ready}, 43'd1); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
  endtask

  task automatic test_dist1();
    present(r_op(6'd1, 5'd3, 5'd1, 5'd2));      // ADD r3 <- r1,r2
    present(r_op(6'd2, 5'd4, 5'd3, 5'd5));      // SUB r4 <- r3,r5
    checks++; if (RA !== 5'd3) begin failures++; $display("FAIL d1_RA got=%0d exp=3", RA); end
    checks++; if (RB !== 5'd5) begin failures++; $display("FAIL d1_RB got=%0d exp=5", RB); end
    checks++; if (alu_op !== 3'd1 || mux_sel_A !== 2'b00) begin failures++; $display("FAIL d1_add_ex got=%0d/%b exp=1/00", alu_op, mux_sel_A); end
    present(i_op(6'd7, 5'd0, 5'd3, 16'h2008));  // ST [r3+0x2008] <- r4
    checks++; if (alu_op !== 3'd2) begin failures++; $display("FAIL d1_sub_alu got=%0d exp=2", alu_op); end
    checks++; if (mux_sel_A !== 2'b01) begin failures++; $display("FAIL d1_sub_selA got=%b exp=01", mux_sel_A); end
    checks++; if (mux_sel_B !== 2'b00) begin failures++; $display("FAIL d1_sub_selB got=%b exp=00", mux_sel_B); end
    checks++; if (RW_dm !== 5'd3) begin failures++; $display("FAIL d1_rwdm got=%0d exp=3", RW_dm); end
    idle(1);
    checks++; if (mux_sel_A !== 2'b10 || mux_sel_B !== 2'b01) begin failures++; $display("FAIL st_sel got=%b/%b exp=10/01", mux_sel_A, mux_sel_B); end
    checks++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || imm_sel !== 1'b1) begin failures++; $display("FAIL st_ctl got=%b%b%b exp=101", mem_wr, mem_rd, imm_sel); end
    checks++; if (imm !== 16'h2008) begin failures++; $display("FAIL st_imm got=%h exp=2008", imm); end
    checks++; if (RW_dm !== 5'd4) begin failures++; $display("FAIL st_rwdm got=%0d exp=4", RW_dm); end
    idle(3);
  endtask

  task automatic test_priority();
    present(r_op(6'd1, 5'd7, 5'd1, 5'd1));
    present(r_op(6'd1, 5'd7, 5'd2, 5'd2));
    present(r_op(6'd1, 5'd8, 5'd7, 5'd7));
    idle(1);
    checks++; if (mux_sel_A !== 2'b01 || mux_sel_B !== 2'b01) begin failures++; $display("FAIL prio_sel got=%b/%b exp=01/01", mux_sel_A, mux_sel_B); end
    checks++; if (RW_dm !== 5'd7) begin failures++; $display("FAIL prio_rwdm got=%0d exp=7", RW_dm); end
    idle(3);
  endtask

  task automatic test_load_use();
    present(i_op(6'd6, 5'd2, 5'd1, 16'hFFFC));  // LD r2 <- [r1-4]
    present(r_op(6'd1, 5'd6, 5'd2, 5'd2));      // ADD r6 <- r2,r2
    instr_valid = 1'b0;
    checks++; if (stall !== 1'b1 || instr_ready !== 1'b0) begin failures++; $display("FAIL lu_stall got=%b/%b exp=1/0", stall, instr_ready); end
    checks++; if (RA !== 5'd2 || RB !== 5'd2) begin failures++; $display("FAIL lu_addr got=%0d/%0d exp=2/2", RA, RB); end
    checks++; if (mem_rd !== 1'b1 || imm_sel !== 1'b1 || imm !== 16'hFFFC) begin failures++; $display("FAIL lu_ld_ex got=%b/%b/%h exp=1/1/fffc", mem_rd, imm_sel, imm); end
    tick();
    checks++; if (stall !== 1'b0 || instr_ready !== 1'b1) begin failures++; $display("FAIL lu_release got=%b/%b exp=0/1", stall, instr_ready); end
    checks++; if (alu_op !== 3'd0 || mem_rd !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%0d/%b exp=0/0", alu_op, mem_rd); end
    tick();
    checks++; if (alu_op !== 3'd1) begin failures++; $display("FAIL lu_add_alu got=%0d exp=1", alu_op); end
    checks++; if (mux_sel_A !== 2'b10 || mux_sel_B !== 2'b10) begin failures++; $display("FAIL lu_sel got=%b/%b exp=10/10", mux_sel_A, mux_sel_B); end
    idle(3);
  endtask

  task automatic test_r0_dist3();
    present(r_op(6'd1, 5'd0, 5'd1, 5'd1));      // ADD r0
    present(r_op(6'd1, 5'd9, 5'd0, 5'd0));      // ADD r9 <- r0,r0
    idle(1);
    checks++; if (mux_sel_A !== 2'b00 || mux_sel_B !== 2'b00 || alu_op !== 3'd1) begin failures++; $display("FAIL r0_sel got=%b/%b/%0d exp=00/00/1", mux_sel_A, mux_sel_B, alu_op); end
    idle(3);
    present(r_op(6'd1, 5'd10, 5'd1, 5'd1));
    present(32'd0);
    present(32'd0);
    checks++; if (RW_dm !== 5'd10) begin failures++; $display("FAIL d2_rwdm got=%0d exp=10", RW_dm); end
    present(r_op(6'd1, 5'd11, 5'd10, 5'd1));
    idle(1);
    checks++; if (mux_sel_A !== 2'b11 || mux_sel_B !== 2'b00) begin failures++; $display("FAIL d3_sel got=%b/%b exp=11/00", mux_sel_A, mux_sel_B); end
    idle(3);
    present(r_op(6'd1, 5'd12, 5'd1, 5'd1));
    present(32'd0);
    present(32'd0);
    present(32'd0);
    present(r_op(6'd1, 5'd13, 5'd12, 5'd12));
    idle(1);
    checks++; if (mux_sel_A !== 2'b00 || mux_sel_B !== 2'b00) begin failures++; $display("FAIL d4_sel got=%b/%b exp=00/00", mux_sel_A, mux_sel_B); end
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [3];
    int idx = 0;
    int nst = 0;
    logic acc;
    prog[0] = i_op(6'd6, 5'd2, 5'd1, 16'd0);    // LD r2 <- [r1]
    prog[1] = i_op(6'd6, 5'd3, 5'd2, 16'd0);    // LD r3 <- [r2]
    prog[2] = r_op(6'd1, 5'd4, 5'd3, 5'd3);     // ADD r4 <- r3,r3
    for (int c = 0; c < 10; c++) begin
      instr_valid = (idx < 3);
      instr = (idx < 3) ? prog[idx] : 32'd0;
      acc = instr_valid && instr_ready;
      if (stall) nst++;
      tick();
      if (acc) idx++;
    end
    instr_valid = 1'b0;
    checks++; if (nst !== 2) begin failures++; $display("FAIL b2b_stalls got=%0d exp=2", nst); end
    checks++; if (idx !== 3) begin failures++; $display("FAIL b2b_accepted got=%0d exp=3", idx); end
    idle(3);
  endtask

  task automatic test_flush_stall();
    present(i_op(6'd6, 5'd2, 5'd1, 16'd0));
    present(r_op(6'd1, 5'd6, 5'd2, 5'd2));
    instr_valid = 1'b0;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL fl_pre_stall got=%b exp=1", stall); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (stall !== 1'b0 || instr_ready !== 1'b1) begin failures++; $display("FAIL fl_release got=%b/%b exp=0/1", stall, instr_ready); end
    checks++; if (alu_op !== 3'd0 || RA !== 5'd0) begin failures++; $display("FAIL fl_bubble got=%0d/%0d exp=0/0", alu_op, RA); end
    tick();
    checks++; if (alu_op !== 3'd0 || mux_sel_A !== 2'b00) begin failures++; $display("FAIL fl_discard got=%0d/%b exp=0/00", alu_op, mux_sel_A); end
    idle(3);
  endtask

  task automatic test_mid_reset();
    present(r_op(6'd1, 5'd9, 5'd1, 5'd1));
    present(i_op(6'd6, 5'd2, 5'd1, 16'hFFFC));
    present(r_op(6'd1, 5'd6, 5'd2, 5'd2));
    instr_valid = 1'b0;
    checks++; if (RW_dm !== 5'd9 || stall !== 1'b1 || mem_rd !== 1'b1) begin failures++; $display("FAIL mr_pre got=%0d/%b/%b exp=9/1/1", RW_dm, stall, mem_rd); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({mux_sel_A, mux_sel_B, imm, imm_sel, alu_op, mem_rd, mem_wr, RW_dm, stall, RA, RB, instr_ready} !== 43'd1) begin
      failures++; $display("FAIL mr_async got=%h exp=%h", {mux_sel_A, mux_sel_B, imm, imm_sel, alu_op, mem_rd, mem_wr, RW_dm, stall, RA, RB, instr_ready}, 43'd1); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    present(r_op(6'd1, 5'd3, 5'd2, 5'd2));
    idle(1);
    checks++; if (alu_op !== 3'd1 || mux_sel_A !== 2'b00 || mux_sel_B !== 2'b00) begin failures++; $display("FAIL mr_first got=%0d/%b/%b exp=1/00/00", alu_op, mux_sel_A, mux_sel_B); end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_dist1();
    test_priority();
    test_load_use();
    test_r0_dist3();
    test_back_to_back();
    test_flush_stall();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
